// File: rtl/hpu_sprite_fetch.sv
// Sprite line fetcher: scans OAM once per logical line, fetches pattern rows into shadow
// registers and commits them at the next line boundary. Optional flip support: HPU_SPRITE_FLIP_EN.
module hpu_sprite_fetch #(
    parameter int          NUM_SLOTS      = 16,
    parameter int          NUM_OAM        = 64,
    parameter logic [15:0] OAM_BASE       = 16'hF000,
    parameter logic [15:0] PATTERN_BASE   = 16'h8000,
    parameter int          VIS_TRUE_LINES = 478
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              true_line,
    input  logic [9:0]              true_column,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [15:0]             addr_out,
    input  logic [7:0]              data_in,
    output logic [NUM_SLOTS*8-1:0]  sprite_x,
    output logic [NUM_SLOTS*8-1:0]  sprite_y,
    output logic [NUM_SLOTS*2-1:0]  sprite_pallet,
    output logic [NUM_SLOTS*24-1:0] sprite_line_buf,
    output logic                    overflow,
    output logic                    overrun
);
    localparam int          CW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [9:0]  VIS      = 10'(VIS_TRUE_LINES);
    localparam logic [5:0]  LAST_ENT = 6'(NUM_OAM - 1);
    localparam logic [CW:0] SLOTS    = (CW+1)'(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;
    state_t state, state_nx;

    logic          start, pend, ovf_sh, match, last_slot;
    logic [7:0]    tgt, tgt_now, d, tile_r;
    logic [5:0]    ent;
    logic [CW:0]   nfill;
    logic [CW-1:0] cur, cur_nx;
    logic [2:0]    step, row_p;
    logic [NUM_SLOTS-1:0] sh_done;
    logic [5:0]    sh_idx [NUM_SLOTS];
    logic [2:0]    sh_row [NUM_SLOTS];
    logic [7:0]    sh_x   [NUM_SLOTS];
    logic [7:0]    sh_y   [NUM_SLOTS];
    logic [1:0]    sh_pal [NUM_SLOTS];
    logic [23:0]   sh_buf [NUM_SLOTS];
    logic [NUM_SLOTS*8-1:0]  cm_x, cm_y;
    logic [NUM_SLOTS*2-1:0]  cm_pal;
    logic [NUM_SLOTS*24-1:0] cm_lb;

    assign start     = (true_column == 10'd0) && !true_line[0];
    assign tgt_now   = (true_line < VIS) ? true_line[8:1] + 8'd1 : 8'd0;
    assign d         = tgt - data_in;
    assign match     = (d[7:3] == 5'd0);
    assign cur_nx    = cur + 1'b1;
    assign last_slot = ({1'b0, cur} == nfill - 1'b1);

`ifdef HPU_SPRITE_FLIP_EN
    logic [NUM_SLOTS-1:0] sh_hf;
    // data_in is the attr byte when row_p is consumed (step 2)
    assign row_p = sh_row[cur] ^ {3{data_in[3]}};
`else
    assign row_p = sh_row[cur];
`endif

    // Unfinished slots commit as off-screen, blank sprites
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        logic [23:0] lb;
`ifdef HPU_SPRITE_FLIP_EN
        logic [23:0] rev;
        for (genvar p = 0; p < 8; p++) begin : g_px
            assign rev[3*p +: 3] = sh_buf[s][3*(7-p) +: 3];
        end
        assign lb = sh_hf[s] ? rev : sh_buf[s];
`else
        assign lb = sh_buf[s];
`endif
        assign cm_x[8*s +: 8]    = sh_done[s] ? sh_x[s]   : 8'hFF;
        assign cm_y[8*s +: 8]    = sh_done[s] ? sh_y[s]   : 8'hF0;
        assign cm_pal[2*s +: 2]  = sh_done[s] ? sh_pal[s] : 2'd0;
        assign cm_lb[24*s +: 24] = sh_done[s] ? lb        : 24'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) state_nx = SCAN;
        else if (pend) begin
            case (state)
                SCAN:    if (ent == LAST_ENT) state_nx = ((nfill != '0) || match) ? FETCH : DONE;
                FETCH:   if (step == 3'd5 && last_slot) state_nx = DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req         <= 1'b0;
            addr_out        <= '0;
            pend            <= 1'b0;
            tgt             <= '0;
            ent             <= '0;
            nfill           <= '0;
            cur             <= '0;
            step            <= '0;
            tile_r          <= '0;
            ovf_sh          <= 1'b0;
            sh_done         <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                sh_idx[s] <= '0; sh_row[s] <= '0; sh_x[s] <= '0;
                sh_y[s]   <= '0; sh_pal[s] <= '0; sh_buf[s] <= '0;
            end
`ifdef HPU_SPRITE_FLIP_EN
            sh_hf           <= '0;
`endif
            sprite_x        <= {NUM_SLOTS{8'hFF}};
            sprite_y        <= {NUM_SLOTS{8'hF0}};
            sprite_pallet   <= '0;
            sprite_line_buf <= '0;
            overflow        <= 1'b0;
            overrun         <= 1'b0;
        end else if (start) begin
            // Commit and restart; any in-flight read is abandoned
            sprite_x        <= cm_x;
            sprite_y        <= cm_y;
            sprite_pallet   <= cm_pal;
            sprite_line_buf <= cm_lb;
            overflow        <= ovf_sh;
            overrun         <= overrun | (state == SCAN) | (state == FETCH);
            mem_req         <= 1'b1;
            addr_out        <= OAM_BASE;
            pend            <= 1'b0;
            tgt             <= tgt_now;
            ent             <= '0;
            nfill           <= '0;
            ovf_sh          <= 1'b0;
            sh_done         <= '0;
        end else begin
            if (mem_req && mem_gnt) begin
                mem_req <= 1'b0;
                pend    <= 1'b1;
            end
            if (pend) begin
                pend <= 1'b0;
                if (state == SCAN) begin
                    if (match) begin
                        if (nfill < SLOTS) begin
                            sh_idx[nfill[CW-1:0]] <= ent;
                            sh_row[nfill[CW-1:0]] <= d[2:0];
                            sh_y[nfill[CW-1:0]]   <= data_in;
                            nfill                 <= nfill + 1'b1;
                        end else begin
                            ovf_sh <= 1'b1;
                        end
                    end
                    if (ent == LAST_ENT) begin
                        cur      <= '0;
                        step     <= '0;
                        mem_req  <= (nfill != '0) || match;
                        addr_out <= OAM_BASE + {8'd0, (nfill != '0) ? sh_idx[0] : ent, 2'b00} + 16'd1;
                    end else begin
                        ent      <= ent + 1'b1;
                        mem_req  <= 1'b1;
                        addr_out <= addr_out + 16'd4;
                    end
                end else if (state == FETCH) begin
                    // x, tile, attr and the three pattern bytes are each consecutive
                    mem_req  <= 1'b1;
                    step     <= step + 1'b1;
                    addr_out <= addr_out + 16'd1;
                    case (step)
                        3'd0: sh_x[cur] <= data_in;
                        3'd1: tile_r <= data_in;
                        3'd2: begin
                            sh_pal[cur] <= data_in[1:0];
                            addr_out    <= PATTERN_BASE + 16'(tile_r) * 16'd24 + 16'(row_p) * 16'd3;
`ifdef HPU_SPRITE_FLIP_EN
                            sh_hf[cur]  <= data_in[2];
`endif
                        end
                        3'd3: sh_buf[cur][7:0]  <= data_in;
                        3'd4: sh_buf[cur][15:8] <= data_in;
                        default: begin
                            sh_buf[cur][23:16] <= data_in;
                            sh_done[cur]       <= 1'b1;
                            step               <= '0;
                            if (last_slot) begin
                                mem_req <= 1'b0;
                            end else begin
                                cur      <= cur_nx;
                                addr_out <= OAM_BASE + {8'd0, sh_idx[cur_nx], 2'b00} + 16'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule
